// File: rtl/pr_counter_core.sv
// -----------------------------------------------------------------------------
// pr_counter_core
//
// Counter core of the PLL counter test design. Everything runs on clk_sys, the
// PLL CLKOUT0 after its BUFG. The core waits for the PLL LOCKED flag to be
// stable for LOCK_HOLD consecutive cycles, then enters RUN. In RUN a prescaler
// produces a one-cycle tick every PRESCALE_DIV cycles. Each tick steps an
// 8-bit LED counter up or down under switch control. A rising edge on sw[2]
// loads the counter from sw[7:3].
//
// Parameters
//   PRESCALE_DIV  clk cycles per count tick (>= 2)
//   LOCK_HOLD     consecutive synchronized-lock cycles needed before RUN (>= 1)
//
// Ports
//   clk         in   1  clk_sys from the PLL BUFG; the only clock
//   rst         in   1  synchronous, active-high reset
//   pll_locked  in   1  PLL LOCKED; asynchronous, 2-flop synchronized here
//   sw          in   8  board switches; asynchronous, 2-flop synchronized here
//                        sw[0] count enable, sw[1] direction (1 = down),
//                        sw[2] load strobe (rising edge), sw[7:3] load value
//   led         out  8  counter value, registered
//   ready       out  1  high while the FSM is in RUN
// -----------------------------------------------------------------------------
module pr_counter_core #(
  parameter int PRESCALE_DIV = 25000000,
  parameter int LOCK_HOLD    = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic [7:0] sw,
  output logic [7:0] led,
  output logic       ready
);

  localparam int PRE_W  = $clog2(PRESCALE_DIV);
  // A hold of one cycle still needs a 1-bit counter to stay well formed.
  localparam int HOLD_W = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_HOLD - 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  logic       lock_meta_reg;
  logic       lock_s_reg;
  logic [7:0] sw_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_meta_reg <= 1'b0;
      lock_s_reg    <= 1'b0;
    end else begin
      lock_meta_reg <= pll_locked;
      lock_s_reg    <= lock_meta_reg;
    end
  end

  // Each switch gets its own independent two-flop chain. The switches are
  // unrelated mechanical inputs, so no cross-bit coherence is implied.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_sw_sync
      logic meta_reg;
      logic sync_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= sw[gi];
          sync_reg <= meta_reg;
        end
      end

      assign sw_s[gi] = sync_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t            state_reg,    state_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [PRE_W-1:0]  pre_reg,      pre_next;
  logic [7:0]        count_reg,    count_next;
  logic              sw2_prev_reg;

  logic counting;
  logic tick;
  logic load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_WAIT_LOCK;
      hold_cnt_reg <= '0;
      pre_reg      <= '0;
      count_reg    <= 8'h00;
      sw2_prev_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      pre_reg      <= pre_next;
      count_reg    <= count_next;
      // The edge register tracks sw_s[2] in every state. A rising edge seen
      // outside RUN is therefore consumed, not replayed on entry to RUN.
      sw2_prev_reg <= sw_s[2];
    end
  end

  // ---------------------------------------------------------------------------
  // Lock qualification FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = '0;

    case (state_reg)
      ST_WAIT_LOCK: begin
        if (lock_s_reg) begin
          state_next = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (!lock_s_reg) begin
          state_next = ST_WAIT_LOCK;
        end else if (hold_cnt_reg == HOLD_LAST) begin
          state_next = ST_RUN;
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end

      ST_RUN: begin
        if (!lock_s_reg) begin
          state_next = ST_WAIT_LOCK;
        end
      end

      default: begin
        state_next = ST_WAIT_LOCK;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Prescaler and counter
  // ---------------------------------------------------------------------------
  // On the cycle that lock is lost in RUN, counting is already false. That
  // edge therefore clears the datapath together with the exit from RUN.
  assign counting = (state_reg == ST_RUN) && lock_s_reg;
  assign tick     = counting && (pre_reg == PRE_LAST);
  assign load     = counting && sw_s[2] && !sw2_prev_reg;

  always_comb begin
    pre_next = '0;
    if (counting && !tick) begin
      pre_next = pre_reg + 1'b1;
    end
  end

  always_comb begin
    count_next = count_reg;
    if (!counting) begin
      count_next = 8'h00;
    end else if (load) begin
      // A load wins over a coincident tick. That tick is simply lost.
      count_next = {3'b000, sw_s[7:3]};
    end else if (tick && sw_s[0]) begin
      if (sw_s[1]) begin
        count_next = count_reg - 8'd1;
      end else begin
        count_next = count_reg + 8'd1;
      end
    end
  end

  assign led   = count_reg;
  assign ready = (state_reg == ST_RUN);

endmodule

// File: tb/tb_pr_counter_core.sv
// -----------------------------------------------------------------------------
// tb_pr_counter_core
//
// Bench for pr_counter_core with PRESCALE_DIV=4 and LOCK_HOLD=8.
// Stimulus is applied at the falling clock edge. Each stimulus step pushes the
// outputs it expects onto a scoreboard queue, tagged with the edge count at
// which they are due. After every rising edge the bench waits for the falling
// edge, then pops and compares every entry that has come due.
// -----------------------------------------------------------------------------
module tb_pr_counter_core;

  localparam int PRESCALE_DIV = 4;
  localparam int LOCK_HOLD    = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic [7:0] sw;
  logic [7:0] led;
  logic       ready;

  pr_counter_core #(
    .PRESCALE_DIV(PRESCALE_DIV),
    .LOCK_HOLD   (LOCK_HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .sw        (sw),
    .led       (led),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] led;
    logic       ready;
    string      name;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       lock;
    logic [7:0] sw;
    int         adv;
    logic [7:0] led;
    logic       ready;
    string      name;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic add_vec(input logic r, input logic l, input logic [7:0] s,
                         input int adv, input logic [7:0] e_led,
                         input logic e_rdy, input string name);
    vec_t v;
    v.rst = r; v.lock = l; v.sw = s; v.adv = adv;
    v.led = e_led; v.ready = e_rdy; v.name = name;
    tbl.push_back(v);
  endtask

  task automatic expect_out(input int after, input logic [7:0] e_led,
                            input logic e_rdy, input string name);
    exp_t e;
    e.due = cyc + after; e.led = e_led; e.ready = e_rdy; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    int i = 0;
    while (i < sb_q.size()) begin
      if (sb_q[i].due <= cyc) begin
        checks++;
        if (led !== sb_q[i].led || ready !== sb_q[i].ready) begin
          errors++;
          $display("FAIL %s edge=%0d led=%02h ready=%0b expected led=%02h ready=%0b",
                   sb_q[i].name, cyc, led, ready, sb_q[i].led, sb_q[i].ready);
        end else begin
          $display("ok   %s edge=%0d led=%02h ready=%0b",
                   sb_q[i].name, cyc, led, ready);
        end
        sb_q.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      drain();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout edge=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b1;
    sw         = 8'h00;

    // Fields: rst, lock, sw, edges to advance, expected led, expected ready.
    // Reset, lock qualification, then up/down counting and wraps.
    add_vec(1, 1, 8'h00,  1, 8'h00, 0, "rst_e1");
    add_vec(1, 1, 8'h00,  1, 8'h00, 0, "rst_e2");
    add_vec(1, 1, 8'h00,  1, 8'h00, 0, "rst_e3");
    add_vec(0, 1, 8'h01, 10, 8'h00, 0, "ready_low_e13");
    add_vec(0, 1, 8'h01,  1, 8'h00, 1, "ready_rise_e14");
    add_vec(0, 1, 8'h01,  3, 8'h00, 1, "run_pre_tick");
    add_vec(0, 1, 8'h01,  1, 8'h01, 1, "up_01");
    add_vec(0, 1, 8'h01,  3, 8'h01, 1, "up_01_hold");
    add_vec(0, 1, 8'h01,  1, 8'h02, 1, "up_02");
    add_vec(0, 1, 8'h03,  3, 8'h02, 1, "dir_flip_hold");
    add_vec(0, 1, 8'h03,  1, 8'h01, 1, "dn_01");
    add_vec(0, 1, 8'h03,  4, 8'h00, 1, "dn_00");
    add_vec(0, 1, 8'h03,  4, 8'hFF, 1, "dn_wrap_ff");
    add_vec(0, 1, 8'h03,  4, 8'hFE, 1, "dn_fe");
    add_vec(0, 1, 8'hFD,  3, 8'h1F, 1, "load_1f");
    add_vec(0, 1, 8'hFD,  1, 8'h20, 1, "up_20_no_wrap");
    add_vec(0, 1, 8'h03,  2, 8'h20, 1, "dn_setup");
    add_vec(0, 1, 8'h07,  2, 8'h1F, 1, "dn_1f");
    add_vec(0, 1, 8'h07,  1, 8'h00, 1, "load_00");
    add_vec(0, 1, 8'h07,  3, 8'hFF, 1, "dn_00_ff");
    add_vec(0, 1, 8'h05,  3, 8'hFF, 1, "up_setup");
    add_vec(0, 1, 8'h05,  1, 8'h00, 1, "up_ff_00");

    foreach (tbl[i]) begin
      rst        = tbl[i].rst;
      pll_locked = tbl[i].lock;
      sw         = tbl[i].sw;
      expect_out(tbl[i].adv, tbl[i].led, tbl[i].ready, tbl[i].name);
      run(tbl[i].adv);
    end

    // Load edge coincident with a tick. sw[7:3]=10101 loads 8'h15 and the
    // tick is dropped. Holding sw[2] high must not reload.
    sw = 8'hA9;
    expect_out(4, 8'h01, 1'b1, "ld_up_01");
    run(5);
    sw = 8'hAD;
    expect_out(2, 8'h01, 1'b1, "ld_before_load");
    expect_out(3, 8'h15, 1'b1, "ld_on_tick");
    expect_out(4, 8'h15, 1'b1, "ld_tick_dropped");
    run(4);
    expect_out(19, 8'h1A, 1'b1, "ld_held_no_reload");
    run(19);

    // Load 07 with counting disabled, then drop lock in RUN.
    sw = 8'h38;
    run(2);
    sw = 8'h3C;
    expect_out(3, 8'h07, 1'b1, "ll_load_07");
    expect_out(6, 8'h07, 1'b1, "ll_en0_hold");
    run(7);
    pll_locked = 1'b0;
    expect_out(2, 8'h07, 1'b1, "ll_sync_lag");
    expect_out(3, 8'h00, 1'b0, "ll_lockloss_clear");
    run(3);

    // Re-lock, one-cycle glitch low at hold_cnt=5, then a full hold again.
    pll_locked = 1'b1;
    run(6);
    pll_locked = 1'b0;
    run(1);
    pll_locked = 1'b1;
    expect_out(4,  8'h00, 1'b0, "gl_no_early_ready");
    expect_out(10, 8'h00, 1'b0, "gl_ready_low");
    expect_out(11, 8'h00, 1'b1, "gl_ready_relock");
    run(11);

    // Reset during HOLD restarts qualification from scratch.
    pll_locked = 1'b0;
    run(3);
    pll_locked = 1'b1;
    run(5);
    rst = 1'b1;
    expect_out(1, 8'h00, 1'b0, "rh_rst_midhold");
    run(2);
    rst = 1'b0;
    expect_out(4,  8'h00, 1'b0, "rh_no_stale_run");
    expect_out(10, 8'h00, 1'b0, "rh_ready_low");
    expect_out(11, 8'h00, 1'b1, "rh_ready_after_rst");
    run(11);

    // Load in RUN, then reset clears a nonzero count on the next edge.
    sw = 8'h38;
    run(2);
    sw = 8'h3C;
    expect_out(3, 8'h07, 1'b1, "rr_load_07");
    run(3);
    rst = 1'b1;
    expect_out(1, 8'h00, 1'b0, "rr_rst_clear");
    run(2);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover pending=%0d expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
